// File: rtl/mem_l15_pkg.sv
// Shared encodings for the core-to-L1.5 bridge: L1.5 request/response types, sizes,
// core op fields, response error codes, FSM states and lane helpers.
package mem_l15_pkg;

   localparam logic [4:0] RqtypeLoad  = 5'b00000;
   localparam logic [4:0] RqtypeStore = 5'b00001;

   localparam logic [3:0] RtLoad  = 4'b0000;
   localparam logic [3:0] RtStore = 4'b0100;

   localparam logic [2:0] SizeB = 3'b001;
   localparam logic [2:0] SizeH = 3'b010;
   localparam logic [2:0] SizeW = 3'b011;
   localparam logic [2:0] SizeD = 3'b100;

   localparam int unsigned OpStoreBit    = 3;
   localparam int unsigned OpUnsignedBit = 2;
   localparam logic [1:0] OpSzB = 2'b00;
   localparam logic [1:0] OpSzH = 2'b01;
   localparam logic [1:0] OpSzW = 2'b10;
   localparam logic [1:0] OpSzD = 2'b11;

   localparam logic [1:0] ErrOk       = 2'b00;
   localparam logic [1:0] ErrMisalign = 2'b01;
   localparam logic [1:0] ErrTimeout  = 2'b10;

   typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

   function automatic logic [2:0] l15_size(input logic [1:0] sz);
      logic [2:0] s;
      unique case (sz)
         OpSzB:   s = SizeB;
         OpSzH:   s = SizeH;
         OpSzW:   s = SizeW;
         default: s = SizeD;
      endcase
      return s;
   endfunction

   function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off,
                                       input logic xlen32);
      logic m;
      unique case (sz)
         OpSzB:   m = 1'b0;
         OpSzH:   m = off[0];
         OpSzW:   m = |off[1:0];
         default: m = xlen32 | (|off);
      endcase
      return m;
   endfunction

   function automatic logic [63:0] bswap64(input logic [63:0] d);
      logic [63:0] r;
      for (int i = 0; i < 8; i++) begin
         r[8*i +: 8] = d[56-8*i +: 8];
      end
      return r;
   endfunction

   function automatic logic [63:0] store_payload(input logic [1:0] sz, input logic [63:0] wd);
      logic [63:0] p;
      unique case (sz)
         OpSzB:   p = {8{wd[7:0]}};
         OpSzH:   p = {4{wd[7:0], wd[15:8]}};
         OpSzW:   p = {2{wd[7:0], wd[15:8], wd[23:16], wd[31:24]}};
         default: p = bswap64(wd);
      endcase
      return p;
   endfunction

   // The L1.5 beat is big-endian (byte 0 in [63:56]); move the lane's last byte to bit 0.
   function automatic logic [63:0] load_result(input logic [63:0] beat, input logic [2:0] off,
                                               input logic [1:0] sz, input logic uns);
      logic [2:0]  nbm1;
      logic [2:0]  lsb_byte;
      logic [63:0] sh;
      logic [63:0] r;
      unique case (sz)
         OpSzB:   nbm1 = 3'd0;
         OpSzH:   nbm1 = 3'd1;
         OpSzW:   nbm1 = 3'd3;
         default: nbm1 = 3'd7;
      endcase
      lsb_byte = ~off - nbm1;
      sh = beat >> {lsb_byte, 3'b000};
      unique case (sz)
         OpSzB:   r = {{56{~uns & sh[7]}}, sh[7:0]};
         OpSzH:   r = {{48{~uns & sh[15]}}, sh[15:0]};
         OpSzW:   r = {{32{~uns & sh[31]}}, sh[31:0]};
         default: r = sh;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/mem_l15_req_fifo.sv
// Request queue for the L1.5 bridge: circular buffer with full/empty flags.
// Push while full is accepted when a pop happens in the same cycle.
module mem_l15_req_fifo #(
   parameter int unsigned Width = 8,
   parameter int unsigned Depth = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);
   localparam int unsigned AW = $clog2(Depth);
   localparam logic [AW-1:0] PtrOne = AW'(1);
   localparam logic [AW:0] CntOne = (AW+1)'(1);
   localparam logic [AW:0] CntFull = (AW+1)'(Depth);

   logic [Width-1:0] mem_q [Depth];
   logic [Width-1:0] mem_d [Depth];
   logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push, do_pop;

   assign full_o  = (cnt_q == CntFull);
   assign empty_o = (cnt_q == '0);
   assign rdata_o = mem_q[rptr_q];
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      cnt_d  = cnt_q;
      if (do_push) begin
         mem_d[wptr_q] = wdata_i;
         wptr_d = wptr_q + PtrOne;
      end
      if (do_pop) begin
         rptr_d = rptr_q + PtrOne;
      end
      if (do_push && !do_pop) begin
         cnt_d = cnt_q + CntOne;
      end else if (do_pop && !do_push) begin
         cnt_d = cnt_q - CntOne;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         cnt_q  <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/mem_l15_bridge.sv
// Core load/store to OpenPiton L1.5 bridge, one request outstanding, in-order responses.
// Define MEM_L15_BRIDGE_TIMEOUT_EN to build the L1.5 response timeout counter.
module mem_l15_bridge
   import mem_l15_pkg::*;
#(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned QDEPTH      = 4,
   parameter int unsigned TIMEOUT_CYC = 1024
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3:0]      req_op,
   input  logic [31:0]     req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_data,
   output logic [1:0]      rsp_err,
   output logic [4:0]      mem_l15_rqtype,
   output logic [2:0]      mem_l15_size,
   output logic [31:0]     mem_l15_address,
   output logic [63:0]     mem_l15_data,
   output logic            mem_l15_val,
   input  logic            l15_mem_header_ack,
   input  logic            l15_mem_val,
   input  logic [3:0]      l15_mem_returntype,
   input  logic [63:0]     l15_mem_data_0,
   input  logic [63:0]     l15_mem_data_1,
   output logic            mem_l15_req_ack
);
   localparam int unsigned QW = 4 + 32 + XLEN;
   localparam logic Xlen32 = (XLEN == 32);

   logic            push, pop, full, empty;
   logic [QW-1:0]   head;
   logic [3:0]      hd_op;
   logic [31:0]     hd_addr;
   logic [XLEN-1:0] hd_wdata;

   assign req_ready = !full;
   assign push      = req_valid && !full;

   mem_l15_req_fifo #(
      .Width (QW),
      .Depth (QDEPTH)
   ) u_req_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .push_i  (push),
      .wdata_i ({req_op, req_addr, req_wdata}),
      .pop_i   (pop),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty)
   );

   assign {hd_op, hd_addr, hd_wdata} = head;

   state_e          state_q, state_d;
   logic [3:0]      op_q, op_d;
   logic [3:0]      lo_addr_q, lo_addr_d;
   logic [XLEN-1:0] rsp_data_q, rsp_data_d;
   logic [1:0]      rsp_err_q, rsp_err_d;
   logic            rsp_match, timeout;
   logic [63:0]     ld_full;

   assign mem_l15_rqtype  = hd_op[OpStoreBit] ? RqtypeStore : RqtypeLoad;
   assign mem_l15_size    = l15_size(hd_op[1:0]);
   assign mem_l15_address = hd_addr;
   assign mem_l15_data    = store_payload(hd_op[1:0], 64'(hd_wdata));
   assign mem_l15_req_ack = l15_mem_val;

   assign rsp_valid = (state_q == StResp);
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

   assign rsp_match = l15_mem_val &&
                      (l15_mem_returntype == (op_q[OpStoreBit] ? RtStore : RtLoad));
   assign ld_full   = load_result(lo_addr_q[3] ? l15_mem_data_1 : l15_mem_data_0,
                                  lo_addr_q[2:0], op_q[1:0], op_q[OpUnsignedBit]);

`ifdef MEM_L15_BRIDGE_TIMEOUT_EN
   localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);
   logic [CntW-1:0] to_cnt_q, to_cnt_d;

   always_comb begin
      to_cnt_d = '0;
      if (state_q == StWait) begin
         to_cnt_d = to_cnt_q + CntOne;
      end
   end

   assign timeout = (state_q == StWait) && (to_cnt_q == CntLast);

   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q <= '0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      lo_addr_d   = lo_addr_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      pop         = 1'b0;
      mem_l15_val = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!empty) begin
               op_d      = hd_op;
               lo_addr_d = hd_addr[3:0];
               if (misaligned(hd_op[1:0], hd_addr[2:0], Xlen32)) begin
                  pop        = 1'b1;
                  rsp_err_d  = ErrMisalign;
                  rsp_data_d = '0;
                  state_d    = StResp;
               end else begin
                  state_d = StReq;
               end
            end
         end
         StReq: begin
            mem_l15_val = 1'b1;
            if (l15_mem_header_ack) begin
               pop     = 1'b1;
               state_d = StWait;
            end
         end
         StWait: begin
            // A matching response beats a timeout expiring in the same cycle.
            if (rsp_match) begin
               rsp_err_d  = ErrOk;
               rsp_data_d = op_q[OpStoreBit] ? '0 : ld_full[XLEN-1:0];
               state_d    = StResp;
            end else if (timeout) begin
               rsp_err_d  = ErrTimeout;
               rsp_data_d = '0;
               state_d    = StResp;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         op_q       <= '0;
         lo_addr_q  <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= ErrOk;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         lo_addr_q  <= lo_addr_d;
         rsp_data_q <= rsp_data_d;
         rsp_err_q  <= rsp_err_d;
      end
   end

endmodule

// File: tb/tb_mem_l15_bridge.sv
// Bench for mem_l15_bridge: directed vectors plus randomized loads/stores against a
// byte-level reference model; the timeout case follows MEM_L15_BRIDGE_TIMEOUT_EN.
module tb_mem_l15_bridge;
   localparam int unsigned XLEN        = 32;
   localparam int unsigned QDEPTH      = 4;
   localparam int unsigned TIMEOUT_CYC = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [3:0]      req_op = '0;
   logic [31:0]     req_addr = '0;
   logic [XLEN-1:0] req_wdata = '0;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [XLEN-1:0] rsp_data;
   logic [1:0]      rsp_err;
   logic [4:0]      mem_l15_rqtype;
   logic [2:0]      mem_l15_size;
   logic [31:0]     mem_l15_address;
   logic [63:0]     mem_l15_data;
   logic            mem_l15_val;
   logic            l15_mem_header_ack = 1'b0;
   logic            l15_mem_val = 1'b0;
   logic [3:0]      l15_mem_returntype = '0;
   logic [63:0]     l15_mem_data_0 = '0;
   logic [63:0]     l15_mem_data_1 = '0;
   logic            mem_l15_req_ack;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [31:0] last_data;
   logic [1:0]  last_err;
   logic [63:0] last_payload;
   logic [4:0]  last_rqtype;
   logic [2:0]  last_size;
   int          last_lat;

   mem_l15_bridge #(
      .XLEN        (XLEN),
      .QDEPTH      (QDEPTH),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_op             (req_op),
      .req_addr           (req_addr),
      .req_wdata          (req_wdata),
      .rsp_valid          (rsp_valid),
      .rsp_ready          (rsp_ready),
      .rsp_data           (rsp_data),
      .rsp_err            (rsp_err),
      .mem_l15_rqtype     (mem_l15_rqtype),
      .mem_l15_size       (mem_l15_size),
      .mem_l15_address    (mem_l15_address),
      .mem_l15_data       (mem_l15_data),
      .mem_l15_val        (mem_l15_val),
      .l15_mem_header_ack (l15_mem_header_ack),
      .l15_mem_val        (l15_mem_val),
      .l15_mem_returntype (l15_mem_returntype),
      .l15_mem_data_0     (l15_mem_data_0),
      .l15_mem_data_1     (l15_mem_data_1),
      .mem_l15_req_ack    (mem_l15_req_ack)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference model: memory bytes on the L1.5 beat are numbered from the MSB end.
   function automatic int nbytes(input logic [3:0] op);
      return 1 << op[1:0];
   endfunction

   function automatic logic m_mis(input logic [3:0] op, input logic [31:0] addr);
      return ((addr % nbytes(op)) != 0) || (op[1:0] == 2'b11 && XLEN == 32);
   endfunction

   function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] addr,
                                          input logic [63:0] b0, input logic [63:0] b1);
      logic [63:0] beat;
      logic [63:0] v;
      int n;
      int off;
      beat = addr[3] ? b1 : b0;
      n    = nbytes(op);
      off  = int'(addr[2:0]);
      v    = '0;
      for (int i = 0; i < n; i++) begin
         v = (v << 8) | 64'(beat[63-8*(off+i) -: 8]);
      end
      if (!op[2] && v[8*n-1]) begin
         v = v | ~((64'd1 << (8*n)) - 64'd1);
      end
      return v[31:0];
   endfunction

   function automatic logic [63:0] m_payload(input logic [3:0] op, input logic [31:0] wd);
      logic [63:0] p;
      int n;
      n = nbytes(op);
      for (int k = 0; k < 8; k++) begin
         p[63-8*k -: 8] = wd[8*(k%n) +: 8];
      end
      return p;
   endfunction

   task automatic push(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd);
      int n;
      n = 0;
      req_valid = 1'b1;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wd;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("push_ready_bound", 64'(req_ready), 64'd1);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic serve(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [63:0] b0, input logic [63:0] b1, input int lat,
                        input logic bad);
      int n;
      n = 0;
      while (!mem_l15_val && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("l15_val", 64'(mem_l15_val), 64'd1);
      last_rqtype  = mem_l15_rqtype;
      last_size    = mem_l15_size;
      last_payload = mem_l15_data;
      check("rqtype", 64'(mem_l15_rqtype), op[3] ? 64'd1 : 64'd0);
      check("size", 64'(mem_l15_size), 64'(op[1:0]) + 64'd1);
      check("address", 64'(mem_l15_address), 64'(addr));
      if (op[3]) check("payload", mem_l15_data, m_payload(op, wd));
      l15_mem_header_ack = 1'b1;
      @(negedge clk);
      l15_mem_header_ack = 1'b0;
      if (bad) begin
         l15_mem_val        = 1'b1;
         l15_mem_returntype = op[3] ? 4'b0000 : 4'b0100;
         l15_mem_data_0     = ~b0;
         l15_mem_data_1     = ~b1;
         check("bad_rt_ack", 64'(mem_l15_req_ack), 64'd1);
         @(negedge clk);
         l15_mem_val = 1'b0;
         check("bad_rt_ignored", 64'(rsp_valid), 64'd0);
      end
      repeat (lat) @(negedge clk);
      l15_mem_val        = 1'b1;
      l15_mem_returntype = op[3] ? 4'b0100 : 4'b0000;
      l15_mem_data_0     = b0;
      l15_mem_data_1     = b1;
      check("req_ack", 64'(mem_l15_req_ack), 64'd1);
      @(negedge clk);
      l15_mem_val    = 1'b0;
      l15_mem_data_0 = {$urandom, $urandom};
      l15_mem_data_1 = {$urandom, $urandom};
   endtask

   task automatic get_rsp(input logic [31:0] exp_data, input logic [1:0] exp_err,
                          input int hold, input int t0, output logic saw_val);
      int n;
      n = 0;
      saw_val = 1'b0;
      while (!rsp_valid && n < 100) begin
         if (mem_l15_val) saw_val = 1'b1;
         @(negedge clk);
         n++;
      end
      check("rsp_valid", 64'(rsp_valid), 64'd1);
      last_lat = cyc - t0;
      repeat (hold) @(negedge clk);
      check("rsp_held", 64'(rsp_valid), 64'd1);
      check("rsp_data", 64'(rsp_data), 64'(exp_data));
      check("rsp_err", 64'(rsp_err), 64'(exp_err));
      last_data = rsp_data;
      last_err  = rsp_err;
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   task automatic complete(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [63:0] b0, input logic [63:0] b1, input int lat,
                           input logic bad, input int hold, input int t0);
      logic mis;
      logic saw;
      logic [31:0] exp_data;
      mis = m_mis(op, addr);
      if (!mis) serve(op, addr, wd, b0, b1, lat, bad);
      exp_data = (mis || op[3]) ? 32'd0 : m_load(op, addr, b0, b1);
      get_rsp(exp_data, mis ? 2'b01 : 2'b00, hold, t0, saw);
      if (mis) check("no_l15_traffic", 64'(saw), 64'd0);
   endtask

   task automatic run_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [63:0] b0, input logic [63:0] b1, input int lat,
                          input logic bad, input int hold);
      int t0;
      t0 = cyc;
      push(op, addr, wd);
      complete(op, addr, wd, b0, b1, lat, bad, hold, t0);
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] addr;
      logic [63:0] b0, b1;
      int          n;
      int          t0;
      logic        saw;

      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_l15_val", 64'(mem_l15_val), 64'd0);
      check("rst_rsp_err", 64'(rsp_err), 64'd0);
      check("rst_rsp_data", 64'(rsp_data), 64'd0);

      // LW at 0x104, minimum latency path
      run_txn(4'b0010, 32'h104, 32'h0, 64'h0011223344556677, 64'h0, 0, 1'b0, 0);
      check("lw_size", 64'(last_size), 64'd3);
      check("lw_data", 64'(last_data), 64'h44556677);
      check("lw_err", 64'(last_err), 64'd0);
      check("lw_latency", 64'(last_lat), 64'd4);

      // LB / LBU at 0x103 with byte 0x80
      run_txn(4'b0000, 32'h103, 32'h0, 64'h0000008080000000, 64'h0, 1, 1'b0, 0);
      check("lb_data", 64'(last_data), 64'hFFFFFF80);
      run_txn(4'b0100, 32'h103, 32'h0, 64'h0000008080000000, 64'h0, 0, 1'b0, 1);
      check("lbu_data", 64'(last_data), 64'h00000080);

      // SH at 0x202
      run_txn(4'b1001, 32'h202, 32'hABCD, 64'h0, 64'h0, 2, 1'b1, 0);
      check("sh_rqtype", 64'(last_rqtype), 64'd1);
      check("sh_size", 64'(last_size), 64'd2);
      check("sh_payload", last_payload, 64'hCDABCDABCDABCDAB);
      check("sh_err", 64'(last_err), 64'd0);

      // Misaligned LW queued behind a good LW
      t0 = cyc;
      push(4'b0010, 32'h108, 32'h0);
      push(4'b0010, 32'h101, 32'h0);
      complete(4'b0010, 32'h108, 32'h0, 64'h0, 64'h89ABCDEF01234567, 0, 1'b0, 0, t0);
      check("order_first_data", 64'(last_data), 64'h89ABCDEF);
      complete(4'b0010, 32'h101, 32'h0, 64'h0, 64'h0, 0, 1'b0, 1, t0);
      check("order_second_err", 64'(last_err), 64'd1);

      // Stray response in IDLE
      l15_mem_val        = 1'b1;
      l15_mem_returntype = 4'b0000;
      check("stray_idle_ack", 64'(mem_l15_req_ack), 64'd1);
      @(negedge clk);
      l15_mem_val = 1'b0;
      check("stray_idle_no_rsp", 64'(rsp_valid), 64'd0);

      // Randomized traffic
      for (int it = 0; it < 40; it++) begin
         op   = 4'($urandom_range(0, 15));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = addr & ~((32'd1 << op[1:0]) - 32'd1);
         b0 = {$urandom, $urandom};
         b1 = {$urandom, $urandom};
         run_txn(op, addr, $urandom, b0, b1, int'($urandom_range(0, 3)),
                 $urandom_range(0, 4) == 0, int'($urandom_range(0, 2)));
      end

      // Fill the queue with header_ack low, then reset mid-WAIT
      req_valid = 1'b1;
      req_op    = 4'b0010;
      req_addr  = 32'h300;
      req_wdata = '0;
      repeat (4) begin
         @(negedge clk);
         req_addr = req_addr + 32'd4;
      end
      check("full_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      check("full_ready_5th", 64'(req_ready), 64'd0);
      check("full_l15_val", 64'(mem_l15_val), 64'd1);
      req_valid = 1'b0;
      l15_mem_header_ack = 1'b1;
      @(negedge clk);
      l15_mem_header_ack = 1'b0;
      check("pop_ready", 64'(req_ready), 64'd1);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midwait_rst_ready", 64'(req_ready), 64'd1);
      check("midwait_rst_val", 64'(mem_l15_val), 64'd0);
      check("midwait_rst_rsp", 64'(rsp_valid), 64'd0);
      l15_mem_val        = 1'b1;
      l15_mem_returntype = 4'b0000;
      check("late_ack", 64'(mem_l15_req_ack), 64'd1);
      @(negedge clk);
      l15_mem_val = 1'b0;
      repeat (3) begin
         check("late_no_rsp", 64'(rsp_valid), 64'd0);
         check("late_no_val", 64'(mem_l15_val), 64'd0);
         @(negedge clk);
      end

      // Response timeout
      push(4'b0010, 32'h400, 32'h0);
      n = 0;
      while (!mem_l15_val && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("to_l15_val", 64'(mem_l15_val), 64'd1);
      l15_mem_header_ack = 1'b1;
      t0 = cyc;
      @(negedge clk);
      l15_mem_header_ack = 1'b0;
`ifdef MEM_L15_BRIDGE_TIMEOUT_EN
      n = 0;
      while (!rsp_valid && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("to_rsp_valid", 64'(rsp_valid), 64'd1);
      check("to_latency", 64'(cyc - t0), 64'd17);
      check("to_err", 64'(rsp_err), 64'd2);
      check("to_data", 64'(rsp_data), 64'd0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
`else
      repeat (40) @(negedge clk);
      check("no_to_rsp_valid", 64'(rsp_valid), 64'd0);
      l15_mem_val        = 1'b1;
      l15_mem_returntype = 4'b0000;
      l15_mem_data_0     = 64'h1234567800000000;
      @(negedge clk);
      l15_mem_val = 1'b0;
      get_rsp(m_load(4'b0010, 32'h400, 64'h1234567800000000, 64'h0), 2'b00, 0, t0, saw);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
